cci_mpf_shim_rsp_order: RTL and testbench
=========================================

// Module: cci_mpf_shim_rsp_order
// PURPOSE
//  Response-side companion to the write/read ordering shim: restores request order on c0 read
//  responses returning from the FIU, which may arrive out of order. Sits between FIU c0 response
//  channel and AFU. Allocates a ROB slot per issued read (slot index travels in FIU mdata) and
//  delivers responses to the AFU strictly in allocation order with the AFU's original mdata.
// PARAMETERS
//  N_ENTRIES          64   ROB depth, power of 2, 8..512
//  DATA_WIDTH         512  response line width
//  MDATA_WIDTH        16   AFU mdata width saved per slot
//  AFU_BUF_THRESHOLD  8    free slots reserved; alloc_almost_full asserts when free <= this
// PORTS
//  clk                  in   1            clock
//  reset_n              in   1            async reset, active low
//  alloc_en             in   1            AFU issues a read this cycle; claim tail slot
//  alloc_mdata          in   MDATA_WIDTH  AFU mdata stored in claimed slot
//  alloc_idx            out  log2(N)      slot index to place in FIU request mdata (= tail)
//  alloc_almost_full    out  1            stop issuing reads
//  fiu_rsp_valid        in   1            FIU read response valid
//  fiu_rsp_idx          in   log2(N)      slot index echoed from FIU mdata
//  fiu_rsp_data         in   DATA_WIDTH   response line
//  afu_rsp_valid        out  1            in-order response to AFU (no backpressure)
//  afu_rsp_data         out  DATA_WIDTH   response line
//  afu_rsp_mdata        out  MDATA_WIDTH  original AFU mdata
//  err_sticky           out  1            protocol error seen since reset
// BEHAVIOUR
//  Reset (async assert, sync deassert internal): head=tail=0, count=0, all slot-valid bits 0,
//   afu_rsp_valid=0, afu_rsp_data/mdata=0, err_sticky=0, alloc_almost_full=0, alloc_idx=0.
//   Reset mid-operation discards all in-flight slots; late FIU responses after reset flag error.
//  Pointers head/tail are log2(N)+1 bits; wrap at 2N; full when MSBs differ, low bits equal.
//  Alloc: alloc_en writes alloc_mdata to mdata RAM[tail], tail++, count++. alloc_en while
//   count==N is dropped and sets err_sticky (caller violated alloc_almost_full).
//  alloc_almost_full = (N - count) <= AFU_BUF_THRESHOLD, registered (one-cycle lag, covered by
//   threshold).
//  Response: fiu_rsp_valid writes data RAM[idx], sets valid[idx]. If valid[idx] already 1 or idx
//   outside [head,tail) -> err_sticky=1, write ignored.
//  Drain: 3-stage pipe. S0: if valid[head] -> clear valid[head], head++, count--, issue RAM reads.
//   S1: RAM read (1-cycle). S2: output register -> afu_rsp_valid=1 one cycle.
//   Min latency fiu_rsp_valid (head slot) -> afu_rsp_valid = 3 cycles. Max 1 response/cycle.
//  Write/read same slot same cycle cannot occur: valid bit set only after write registers; S0
//   sees valid next cycle.
//  Simultaneous alloc + drain: count unchanged; tail/head both advance.
//  Slot reuse: slot is free when head passes it; alloc may reuse same cycle it frees (count
//   update ordered so full/empty correct).
//  Empty (head==tail): no drain, afu_rsp_valid=0. Out-of-order arrivals held until head valid.
// STRUCTURE
//  Package cci_mpf_shim_rsp_order_pkg: t_rob_idx, t_rob_ptr (idx+1 bits), t_rob_mdata,
//   localparam N_IDX_BITS = $clog2(N_ENTRIES).
//  Sub-module cci_mpf_shim_rsp_order_ram: simple dual-port RAM, 1 write + 1 read port, 1-cycle
//   registered read; instanced twice (data, mdata). Valid bits and pointers in flops in top.
// TESTING
//  1) Alloc 4 (mdata 0x10..0x13), responses idx 3,2,1,0 back-to-back -> first afu_rsp_valid
//   3 cycles after idx0 arrives; 4 consecutive outputs mdata 0x10,0x11,0x12,0x13 with matching data.
//  2) Alloc 1, response next cycle -> afu_rsp_valid exactly 3 cycles after fiu_rsp_valid, count 0.
//  3) Fill to N-8 (N=64) -> alloc_almost_full=1 at free=8; drain one -> deasserts next cycle.
//  4) Run 3*N allocs with random-order responses -> pointers wrap, output order == alloc order,
//   err_sticky stays 0.
//  5) Duplicate response idx 5, and response to unallocated idx 20 -> err_sticky=1, outputs unaffected.
//  6) Assert reset_n=0 with 10 slots in flight -> all outputs 0 immediately; after release
//   count=0, alloc_idx=0, no spurious afu_rsp_valid.

Source files
------------

// File: rtl/cci_mpf_shim_rsp_order_pkg.sv
// Shared configuration and types for the c0 read-response reorder buffer.
// The ROB geometry is set here; the top, interface and bench all derive widths from it.
package cci_mpf_shim_rsp_order_pkg;

  localparam int N_ENTRIES         = 64;
  localparam int DATA_WIDTH        = 512;
  localparam int MDATA_WIDTH       = 16;
  localparam int AFU_BUF_THRESHOLD = 8;
  localparam int N_IDX_BITS        = $clog2(N_ENTRIES);

  typedef logic [N_IDX_BITS-1:0]  t_rob_idx;
  typedef logic [N_IDX_BITS:0]    t_rob_ptr;
  typedef logic [MDATA_WIDTH-1:0] t_rob_mdata;
  typedef logic [DATA_WIDTH-1:0]  t_rob_data;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  function automatic t_rob_idx rob_slot(input t_rob_ptr p);
    return p[N_IDX_BITS-1:0];
  endfunction

endpackage

// File: rtl/cci_mpf_shim_rsp_order_if.sv
// Allocation and response channels of the reorder buffer.
// The AFU/FIU side drives through master; the ROB itself connects as slave.
interface cci_mpf_shim_rsp_order_if;
  import cci_mpf_shim_rsp_order_pkg::*;

  logic       alloc_en;
  t_rob_mdata alloc_mdata;
  t_rob_idx   alloc_idx;
  logic       alloc_almost_full;

  logic       fiu_rsp_valid;
  t_rob_idx   fiu_rsp_idx;
  t_rob_data  fiu_rsp_data;

  logic       afu_rsp_valid;
  t_rob_data  afu_rsp_data;
  t_rob_mdata afu_rsp_mdata;
  logic       err_sticky;

  modport master (
    output alloc_en, alloc_mdata, fiu_rsp_valid, fiu_rsp_idx, fiu_rsp_data,
    input  alloc_idx, alloc_almost_full, afu_rsp_valid, afu_rsp_data,
           afu_rsp_mdata, err_sticky
  );

  modport slave (
    input  alloc_en, alloc_mdata, fiu_rsp_valid, fiu_rsp_idx, fiu_rsp_data,
    output alloc_idx, alloc_almost_full, afu_rsp_valid, afu_rsp_data,
           afu_rsp_mdata, err_sticky
  );

endinterface

// File: rtl/cci_mpf_shim_rsp_order_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered read.
// A read and a write to the same address in one cycle return the old contents.
module cci_mpf_shim_rsp_order_ram #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/cci_mpf_shim_rsp_order.sv
// Reorder buffer for c0 read responses: slots are claimed at issue, filled out of order by the
// FIU, and drained to the AFU strictly in allocation order with the AFU's original mdata.
module cci_mpf_shim_rsp_order
  import cci_mpf_shim_rsp_order_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  cci_mpf_shim_rsp_order_if.slave rob
);

  logic [1:0] rst_sync;
  logic       rst_n_int;

  t_rob_ptr             head, tail, count, free_slots;
  t_rob_idx             head_idx, tail_idx, rsp_offset;
  logic [N_ENTRIES-1:0] slot_valid, set_mask, clr_mask;
  logic                 full, alloc_ok, drain, rsp_in_range, rsp_ok, rsp_err;
  logic                 almost_full_q, err_q;

  logic       s1_valid, afu_valid_q;
  t_rob_data  ram_data, afu_data_q;
  t_rob_mdata ram_mdata, afu_mdata_q;

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_int = rst_sync[1];

  assign head_idx   = rob_slot(head);
  assign tail_idx   = rob_slot(tail);
  assign full       = (head[N_IDX_BITS] != tail[N_IDX_BITS]) && (head_idx == tail_idx);
  assign drain      = slot_valid[head_idx];
  // A slot being drained this cycle may be reclaimed in the same cycle.
  assign alloc_ok   = rob.alloc_en && (!full || drain);
  assign free_slots = t_rob_ptr'(N_ENTRIES) - count;

  assign rsp_offset   = rob.fiu_rsp_idx - head_idx;
  assign rsp_in_range = ({1'b0, rsp_offset} < count);
  assign rsp_ok       = rob.fiu_rsp_valid && rsp_in_range && !slot_valid[rob.fiu_rsp_idx];
  assign rsp_err      = rob.fiu_rsp_valid && !rsp_ok;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (rsp_ok) set_mask[rob.fiu_rsp_idx] = 1'b1;
    if (drain)  clr_mask[head_idx]        = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      slot_valid    <= '0;
      almost_full_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      if (alloc_ok) tail <= tail + 1'b1;
      if (drain)    head <= head + 1'b1;
      count         <= count + t_rob_ptr'(alloc_ok) - t_rob_ptr'(drain);
      slot_valid    <= (slot_valid & ~clr_mask) | set_mask;
      almost_full_q <= (free_slots <= t_rob_ptr'(AFU_BUF_THRESHOLD));
      if ((rob.alloc_en && !alloc_ok) || rsp_err) err_q <= 1'b1;
    end
  end

  cci_mpf_shim_rsp_order_ram #(.WIDTH(DATA_WIDTH), .DEPTH(N_ENTRIES)) u_data_ram (
    .clk     (clk),
    .wr_en   (rsp_ok),
    .wr_addr (rob.fiu_rsp_idx),
    .wr_data (rob.fiu_rsp_data),
    .rd_en   (drain),
    .rd_addr (head_idx),
    .rd_data (ram_data)
  );

  cci_mpf_shim_rsp_order_ram #(.WIDTH(MDATA_WIDTH), .DEPTH(N_ENTRIES)) u_mdata_ram (
    .clk     (clk),
    .wr_en   (alloc_ok),
    .wr_addr (tail_idx),
    .wr_data (rob.alloc_mdata),
    .rd_en   (drain),
    .rd_addr (head_idx),
    .rd_data (ram_mdata)
  );

  // Drain pipe: RAM read stage, then the AFU output register.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      s1_valid    <= 1'b0;
      afu_valid_q <= 1'b0;
      afu_data_q  <= '0;
      afu_mdata_q <= '0;
    end else begin
      s1_valid    <= drain;
      afu_valid_q <= s1_valid;
      if (s1_valid) begin
        afu_data_q  <= ram_data;
        afu_mdata_q <= ram_mdata;
      end
    end
  end

  assign rob.alloc_idx         = tail_idx;
  assign rob.alloc_almost_full = almost_full_q;
  assign rob.afu_rsp_valid     = afu_valid_q;
  assign rob.afu_rsp_data      = afu_data_q;
  assign rob.afu_rsp_mdata     = afu_mdata_q;
  assign rob.err_sticky        = err_q;

endmodule

// File: tb/tb_cci_mpf_shim_rsp_order.sv
// Directed bench for the c0 response reorder buffer: ordering, latency, almost-full,
// pointer wrap, protocol errors and reset in flight.
module tb_cci_mpf_shim_rsp_order;
  import cci_mpf_shim_rsp_order_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  cci_mpf_shim_rsp_order_if bus();

  cci_mpf_shim_rsp_order dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rob     (bus)
  );

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int tail_m = 0;
  int seq    = 0;

  t_rob_mdata got_md[$];
  t_rob_data  got_data[$];
  int         got_cyc[$];
  t_rob_mdata exp_md[$];
  t_rob_data  exp_data[$];
  t_rob_mdata slot_md[N_ENTRIES];
  t_rob_data  slot_data[N_ENTRIES];

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every AFU response away from the active edge.
  always @(negedge clk) begin
    if (bus.afu_rsp_valid) begin
      got_md.push_back(bus.afu_rsp_mdata);
      got_data.push_back(bus.afu_rsp_data);
      got_cyc.push_back(cyc);
    end
  end

  function automatic t_rob_data mk_data(input int s);
    logic [31:0] w;
    w = 32'hD000_0000 ^ 32'(s);
    return {16{w}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.alloc_en      = 1'b0;
    bus.alloc_mdata   = '0;
    bus.fiu_rsp_valid = 1'b0;
    bus.fiu_rsp_idx   = '0;
    bus.fiu_rsp_data  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic clear_queues();
    got_md.delete();
    got_data.delete();
    got_cyc.delete();
    exp_md.delete();
    exp_data.delete();
  endtask

  task automatic alloc_one(input t_rob_mdata md);
    int slot;
    slot = tail_m % N_ENTRIES;
    slot_md[slot]   = md;
    slot_data[slot] = mk_data(seq);
    seq++;
    exp_md.push_back(md);
    exp_data.push_back(slot_data[slot]);
    bus.alloc_en    = 1'b1;
    bus.alloc_mdata = md;
    step();
    clear_inputs();
    tail_m++;
  endtask

  task automatic respond(input int idx, input t_rob_data d);
    bus.fiu_rsp_valid = 1'b1;
    bus.fiu_rsp_idx   = t_rob_idx'(idx);
    bus.fiu_rsp_data  = d;
    step();
    clear_inputs();
  endtask

  task automatic wait_outputs(input int n, input int budget);
    int k;
    k = 0;
    while (got_md.size() < n && k < budget) begin
      step();
      k++;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(3);
    tail_m = 0;
    clear_queues();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    idle(2);
    total++; if (bus.afu_rsp_valid !== 1'b0) $display("[TB] FAIL rst_valid: got %b expected 0", bus.afu_rsp_valid); else passed++;
    total++; if (bus.afu_rsp_data !== '0) $display("[TB] FAIL rst_data: got %h expected 0", bus.afu_rsp_data); else passed++;
    total++; if (bus.afu_rsp_mdata !== '0) $display("[TB] FAIL rst_mdata: got %h expected 0", bus.afu_rsp_mdata); else passed++;
    total++; if (bus.alloc_idx !== '0) $display("[TB] FAIL rst_alloc_idx: got %0d expected 0", bus.alloc_idx); else passed++;
    total++; if (bus.alloc_almost_full !== 1'b0) $display("[TB] FAIL rst_af: got %b expected 0", bus.alloc_almost_full); else passed++;
    total++; if (bus.err_sticky !== 1'b0) $display("[TB] FAIL rst_err: got %b expected 0", bus.err_sticky); else passed++;
    reset_n = 1'b1;
    idle(4);
    total++; if (bus.afu_rsp_valid !== 1'b0) $display("[TB] FAIL post_rst_valid: got %b expected 0", bus.afu_rsp_valid); else passed++;
    total++; if (bus.err_sticky !== 1'b0) $display("[TB] FAIL post_rst_err: got %b expected 0", bus.err_sticky); else passed++;
    tail_m = 0;
    clear_queues();
  endtask

  task automatic test_reorder();
    int t0;
    clear_queues();
    for (int i = 0; i < 4; i++) alloc_one(t_rob_mdata'(16'h0010 + i));
    total++; if (bus.alloc_idx !== t_rob_idx'(4)) $display("[TB] FAIL reorder_alloc_idx: got %0d expected 4", bus.alloc_idx); else passed++;
    respond(3, slot_data[3]);
    respond(2, slot_data[2]);
    respond(1, slot_data[1]);
    t0 = cyc;
    respond(0, slot_data[0]);
    wait_outputs(4, 20);
    total++; if (got_md.size() !== 4) $display("[TB] FAIL reorder_count: got %0d expected 4", got_md.size()); else passed++;
    for (int i = 0; i < 4 && i < got_md.size(); i++) begin
      total++;
      if (got_md[i] !== t_rob_mdata'(16'h0010 + i) || got_data[i] !== slot_data[i] || got_cyc[i] !== t0 + 3 + i)
        $display("[TB] FAIL reorder_out%0d: got mdata %h cycle %0d expected mdata %h cycle %0d", i, got_md[i], got_cyc[i], 16'h0010 + i, t0 + 3 + i);
      else passed++;
    end
    total++; if (bus.err_sticky !== 1'b0) $display("[TB] FAIL reorder_err: got %b expected 0", bus.err_sticky); else passed++;
  endtask

  task automatic test_single();
    int slot, t0;
    clear_queues();
    slot = tail_m % N_ENTRIES;
    alloc_one(16'h0020);
    t0 = cyc;
    respond(slot, slot_data[slot]);
    wait_outputs(1, 20);
    idle(5);
    total++; if (got_md.size() !== 1) $display("[TB] FAIL single_count: got %0d expected 1", got_md.size()); else passed++;
    if (got_md.size() > 0) begin
      total++;
      if (got_cyc[0] !== t0 + 3) $display("[TB] FAIL single_latency: got %0d expected %0d", got_cyc[0] - t0, 3); else passed++;
      total++;
      if (got_md[0] !== 16'h0020 || got_data[0] !== slot_data[slot]) $display("[TB] FAIL single_payload: got mdata %h expected 0020", got_md[0]); else passed++;
    end
    total++; if (bus.alloc_idx !== t_rob_idx'(5)) $display("[TB] FAIL single_alloc_idx: got %0d expected 5", bus.alloc_idx); else passed++;
    total++; if (bus.alloc_almost_full !== 1'b0) $display("[TB] FAIL single_af: got %b expected 0", bus.alloc_almost_full); else passed++;
  endtask

  task automatic test_almost_full();
    int start;
    clear_queues();
    start = tail_m;
    for (int i = 0; i < 55; i++) alloc_one(t_rob_mdata'(16'h3000 + i));
    idle(2);
    total++; if (bus.alloc_almost_full !== 1'b0) $display("[TB] FAIL af_free9: got %b expected 0", bus.alloc_almost_full); else passed++;
    alloc_one(16'h3037);
    total++; if (bus.alloc_almost_full !== 1'b0) $display("[TB] FAIL af_lag: got %b expected 0", bus.alloc_almost_full); else passed++;
    step();
    total++; if (bus.alloc_almost_full !== 1'b1) $display("[TB] FAIL af_free8: got %b expected 1", bus.alloc_almost_full); else passed++;
    respond(start % N_ENTRIES, slot_data[start % N_ENTRIES]);
    total++; if (bus.alloc_almost_full !== 1'b1) $display("[TB] FAIL af_hold1: got %b expected 1", bus.alloc_almost_full); else passed++;
    step();
    total++; if (bus.alloc_almost_full !== 1'b1) $display("[TB] FAIL af_hold2: got %b expected 1", bus.alloc_almost_full); else passed++;
    step();
    total++; if (bus.alloc_almost_full !== 1'b0) $display("[TB] FAIL af_release: got %b expected 0", bus.alloc_almost_full); else passed++;
    for (int i = 1; i < 56; i++) respond((start + i) % N_ENTRIES, slot_data[(start + i) % N_ENTRIES]);
    wait_outputs(56, 100);
    idle(4);
    total++; if (got_md.size() !== 56) $display("[TB] FAIL af_drain_count: got %0d expected 56", got_md.size()); else passed++;
    for (int i = 0; i < 56 && i < got_md.size(); i++) begin
      total++;
      if (got_md[i] !== exp_md[i] || got_data[i] !== exp_data[i]) $display("[TB] FAIL af_out%0d: got mdata %h expected %h", i, got_md[i], exp_md[i]); else passed++;
    end
  endtask

  task automatic test_wrap();
    int base, j, tmp;
    int slots[16];
    clear_queues();
    for (int b = 0; b < 12; b++) begin
      base = tail_m;
      for (int i = 0; i < 16; i++) alloc_one(t_rob_mdata'(16'h4000 + b * 16 + i));
      for (int i = 0; i < 16; i++) slots[i] = (base + i) % N_ENTRIES;
      for (int i = 15; i > 0; i--) begin
        j = int'($urandom_range(i, 0));
        tmp = slots[i];
        slots[i] = slots[j];
        slots[j] = tmp;
      end
      for (int i = 0; i < 16; i++) respond(slots[i], slot_data[slots[i]]);
    end
    wait_outputs(192, 400);
    idle(4);
    total++; if (got_md.size() !== 192) $display("[TB] FAIL wrap_count: got %0d expected 192", got_md.size()); else passed++;
    for (int i = 0; i < 192 && i < got_md.size(); i++) begin
      total++;
      if (got_md[i] !== exp_md[i] || got_data[i] !== exp_data[i]) $display("[TB] FAIL wrap_out%0d: got mdata %h expected %h", i, got_md[i], exp_md[i]); else passed++;
    end
    total++; if (bus.err_sticky !== 1'b0) $display("[TB] FAIL wrap_err: got %b expected 0", bus.err_sticky); else passed++;
  endtask

  task automatic test_reset_inflight();
    int start;
    clear_queues();
    start = tail_m;
    for (int i = 0; i < 10; i++) alloc_one(t_rob_mdata'(16'h5500 + i));
    for (int i = 1; i < 4; i++) respond((start + i) % N_ENTRIES, slot_data[(start + i) % N_ENTRIES]);
    total++; if (bus.alloc_idx !== t_rob_idx'((start + 10) % N_ENTRIES)) $display("[TB] FAIL inflight_alloc_idx: got %0d expected %0d", bus.alloc_idx, (start + 10) % N_ENTRIES); else passed++;
    reset_n = 1'b0;
    #1;
    total++; if (bus.alloc_idx !== '0) $display("[TB] FAIL async_alloc_idx: got %0d expected 0", bus.alloc_idx); else passed++;
    total++; if (bus.afu_rsp_data !== '0 || bus.afu_rsp_mdata !== '0) $display("[TB] FAIL async_rsp: got mdata %h expected 0", bus.afu_rsp_mdata); else passed++;
    total++; if (bus.afu_rsp_valid !== 1'b0 || bus.alloc_almost_full !== 1'b0 || bus.err_sticky !== 1'b0) $display("[TB] FAIL async_flags: got %b%b%b expected 000", bus.afu_rsp_valid, bus.alloc_almost_full, bus.err_sticky); else passed++;
    idle(3);
    reset_n = 1'b1;
    tail_m = 0;
    clear_queues();
    idle(8);
    total++; if (bus.alloc_idx !== '0) $display("[TB] FAIL post_inflight_alloc_idx: got %0d expected 0", bus.alloc_idx); else passed++;
    total++; if (got_md.size() !== 0) $display("[TB] FAIL post_inflight_spurious: got %0d expected 0", got_md.size()); else passed++;
    total++; if (bus.alloc_almost_full !== 1'b0) $display("[TB] FAIL post_inflight_af: got %b expected 0", bus.alloc_almost_full); else passed++;
    respond((start + 4) % N_ENTRIES, mk_data(555));
    step();
    total++; if (bus.err_sticky !== 1'b1) $display("[TB] FAIL late_rsp_err: got %b expected 1", bus.err_sticky); else passed++;
    total++; if (got_md.size() !== 0) $display("[TB] FAIL late_rsp_output: got %0d expected 0", got_md.size()); else passed++;
  endtask

  task automatic test_errors();
    do_reset();
    total++; if (bus.err_sticky !== 1'b0) $display("[TB] FAIL err_cleared: got %b expected 0", bus.err_sticky); else passed++;
    for (int i = 0; i < 8; i++) alloc_one(t_rob_mdata'(16'h0050 + i));
    respond(5, slot_data[5]);
    step();
    total++; if (bus.err_sticky !== 1'b0) $display("[TB] FAIL dup_first: got %b expected 0", bus.err_sticky); else passed++;
    respond(5, mk_data(999));
    step();
    total++; if (bus.err_sticky !== 1'b1) $display("[TB] FAIL dup_second: got %b expected 1", bus.err_sticky); else passed++;
    for (int i = 0; i < 8; i++) if (i != 5) respond(i, slot_data[i]);
    wait_outputs(8, 40);
    idle(5);
    total++; if (got_md.size() !== 8) $display("[TB] FAIL dup_count: got %0d expected 8", got_md.size()); else passed++;
    for (int i = 0; i < 8 && i < got_md.size(); i++) begin
      total++;
      if (got_md[i] !== exp_md[i] || got_data[i] !== exp_data[i]) $display("[TB] FAIL dup_out%0d: got mdata %h expected %h", i, got_md[i], exp_md[i]); else passed++;
    end

    do_reset();
    for (int i = 0; i < 8; i++) alloc_one(t_rob_mdata'(16'h0060 + i));
    respond(20, mk_data(777));
    step();
    total++; if (bus.err_sticky !== 1'b1) $display("[TB] FAIL unalloc_err: got %b expected 1", bus.err_sticky); else passed++;
    for (int i = 0; i < 8; i++) respond(i, slot_data[i]);
    wait_outputs(8, 40);
    idle(5);
    total++; if (got_md.size() !== 8) $display("[TB] FAIL unalloc_count: got %0d expected 8", got_md.size()); else passed++;
    for (int i = 0; i < 8 && i < got_md.size(); i++) begin
      total++;
      if (got_md[i] !== exp_md[i] || got_data[i] !== exp_data[i]) $display("[TB] FAIL unalloc_out%0d: got mdata %h expected %h", i, got_md[i], exp_md[i]); else passed++;
    end

    do_reset();
    for (int i = 0; i < 64; i++) alloc_one(t_rob_mdata'(16'h0100 + i));
    step();
    total++; if (bus.alloc_idx !== '0 || bus.err_sticky !== 1'b0 || bus.alloc_almost_full !== 1'b1) $display("[TB] FAIL full_state: got idx %0d err %b af %b expected idx 0 err 0 af 1", bus.alloc_idx, bus.err_sticky, bus.alloc_almost_full); else passed++;
    bus.alloc_en    = 1'b1;
    bus.alloc_mdata = 16'hDEAD;
    step();
    clear_inputs();
    total++; if (bus.err_sticky !== 1'b1) $display("[TB] FAIL overflow_err: got %b expected 1", bus.err_sticky); else passed++;
    total++; if (bus.alloc_idx !== '0) $display("[TB] FAIL overflow_idx: got %0d expected 0", bus.alloc_idx); else passed++;
    for (int i = 0; i < 64; i++) respond(i, slot_data[i]);
    wait_outputs(64, 200);
    idle(5);
    total++; if (got_md.size() !== 64) $display("[TB] FAIL full_count: got %0d expected 64", got_md.size()); else passed++;
    for (int i = 0; i < 64 && i < got_md.size(); i++) begin
      total++;
      if (got_md[i] !== exp_md[i] || got_data[i] !== exp_data[i]) $display("[TB] FAIL full_out%0d: got mdata %h expected %h", i, got_md[i], exp_md[i]); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_reorder();
    test_single();
    test_almost_full();
    test_wrap();
    test_reset_inflight();
    test_errors();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
